// File: rtl/vga_sprite_scheduler_pkg.sv
// rtl/vga_sprite_scheduler_pkg.sv - shared encodings, geometry and helpers for the sprite scheduler
// Purpose: mode/mask/BCD-state encodings, sprite geometry, stage-1 sprite record, address helpers.
// Ports: none (package).
package vga_sprite_scheduler_pkg;

  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int BIRD_X = 160;
  localparam int BIRD_W = 34;
  localparam int BIRD_H = 24;
  localparam int PIPE_W = 52;
  localparam int GAP_H  = 120;
  localparam int DIG_W  = 24;
  localparam int DIG_H  = 36;
  localparam int DIG_X  = 284;
  localparam int DIG_Y  = 20;
  localparam int GG_X   = 224;
  localparam int GG_Y   = 180;
  localparam int GG_W   = 192;
  localparam int GG_H   = 42;
  localparam int TT_X   = 231;
  localparam int TT_Y   = 120;
  localparam int TT_W   = 178;
  localparam int TT_H   = 48;
  localparam int DIG_ROM_BASE = 864;  // one digit glyph = 24*36 words

  // Slots in the per-pixel sprite record array
  localparam int SPR_BIRD  = 0;
  localparam int SPR_PIPE0 = 1;
  localparam int SPR_PIPE1 = 2;
  localparam int SPR_DIG0  = 3;  // digits occupy 3..5, hundreds first
  localparam int SPR_GG    = 6;
  localparam int SPR_TT    = 7;
  localparam int N_SPR     = 8;

  typedef enum logic [1:0] {
    MODE_TITLE = 2'd0,
    MODE_PLAY  = 2'd1,
    MODE_OVER  = 2'd2
  } mode_t;

  typedef enum logic [2:0] {
    MASK_BKG      = 3'd0,
    MASK_BIRD     = 3'd1,
    MASK_PIPE     = 3'd2,
    MASK_NUMBER   = 3'd3,
    MASK_GAMEOVER = 3'd4,
    MASK_TITLE    = 3'd5
  } mask_t;

  typedef enum logic [1:0] {
    BCD_IDLE  = 2'd0,
    BCD_SHIFT = 2'd1,
    BCD_DONE  = 2'd2
  } bcd_state_t;

  typedef struct packed {
    logic       hit;
    logic [9:0] lx;
    logic [8:0] ly;
  } spr_t;

  function automatic logic [18:0] rom_addr(input logic [8:0] ly, input logic [9:0] lx, input int w);
    return 19'(ly) * 19'(w) + 19'(lx);
  endfunction

  // Pipe body is solid everywhere in its column except inside the gap
  function automatic logic pipe_solid(input logic [8:0] y, input logic [8:0] gap);
    return (y < gap) || ({1'b0, y} >= ({1'b0, gap} + 10'(GAP_H)));
  endfunction

endpackage

// File: rtl/vga_sprite_scheduler_if.sv
// rtl/vga_sprite_scheduler_if.sv - scan-position in / compositor-address out bundle
// Purpose: groups the pixel request and the delayed compositor outputs.
// Ports: pix_valid/pix_x/pix_y (master->slave); oaddress/address/mask/out_valid (slave->master).
interface vga_sprite_if;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [18:0] oaddress;
  logic [18:0] address;
  logic [2:0]  mask;
  logic        out_valid;

  modport master (output pix_valid, pix_x, pix_y, input oaddress, address, mask, out_valid);
  modport slave  (input pix_valid, pix_x, pix_y, output oaddress, address, mask, out_valid);
endinterface

// File: rtl/vga_sprite_scheduler_sprite_hit_calc.sv
// rtl/vga_sprite_scheduler_sprite_hit_calc.sv - rectangle hit test and sprite-local coordinates
// Purpose: flags x in [x0,x0+W) and y in [y0,y0+H) without wrap; gives lx/ly relative to origin.
// Ports: x_i/y_i scan position, x0_i/y0_i sprite origin, hit_o, lx_o, ly_o.
module sprite_hit_calc #(
  parameter int W = 1,
  parameter int H = 1
) (
  input  logic [9:0] x_i,
  input  logic [8:0] y_i,
  input  logic [9:0] x0_i,
  input  logic [8:0] y0_i,
  output logic       hit_o,
  output logic [9:0] lx_o,
  output logic [8:0] ly_o
);
  logic [10:0] x_end;
  logic [9:0]  y_end;

  // One extra bit so a sprite near the right/bottom edge does not wrap its end
  assign x_end = {1'b0, x0_i} + 11'(W);
  assign y_end = {1'b0, y0_i} + 10'(H);
  assign hit_o = (x_i >= x0_i) && ({1'b0, x_i} < x_end) && (y_i >= y0_i) && ({1'b0, y_i} < y_end);
  assign lx_o  = x_i - x0_i;
  assign ly_o  = y_i - y0_i;
endmodule

// File: rtl/vga_sprite_scheduler.sv
// rtl/vga_sprite_scheduler.sv - per-pixel sprite owner/address resolver with frame-shadowed state
// Purpose: 2-cycle pipeline producing background address, sprite ROM address and mask code.
// Ports: clock, resetn (async low); vif (slave: pix in, oaddress/address/mask/out_valid out);
//        frame_tick, live game state (bird_y, pipe*_x, gap*_y, score), start_btn, hit; mode out.
module vga_sprite_scheduler
  import vga_sprite_scheduler_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  vga_sprite_if.slave vif,
  input  logic        frame_tick,
  input  logic [8:0]  bird_y,
  input  logic [9:0]  pipe0_x,
  input  logic [9:0]  pipe1_x,
  input  logic [8:0]  gap0_y,
  input  logic [8:0]  gap1_y,
  input  logic [9:0]  score,
  input  logic        start_btn,
  input  logic        hit,
  output logic [1:0]  mode
);
  mode_t      mode_q, mode_d;
  logic       pend_start_q, pend_start_d, pend_hit_q, pend_hit_d;
  logic       start_any, hit_any;
  logic [8:0] bird_y_q, gap0_y_q, gap1_y_q;
  logic [9:0] pipe0_x_q, pipe1_x_q;

  bcd_state_t bcd_st_q, bcd_st_d;
  logic [9:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d, bcd_adj, digits_q, digits_d;
  logic [3:0]  bcnt_q, bcnt_d;

  logic [N_SPR-1:0] hit_w;
  logic [9:0]       lx_w [N_SPR];
  logic [8:0]       ly_w [N_SPR];
  spr_t [N_SPR-1:0] s1_q, s1_d;
  logic             s1_valid_q;
  logic [18:0]      s1_oaddr_q;

  logic        dig_hit;
  logic [18:0] dig_addr, address_d, address_q, oaddress_q;
  mask_t       mask_d, mask_q;
  logic        out_valid_q;

  // Mode FSM: requests accumulate all frame, resolved only at the tick
  assign start_any = pend_start_q | start_btn;
  assign hit_any   = pend_hit_q | hit;

  always_comb begin
    mode_d       = mode_q;
    pend_start_d = start_any;
    pend_hit_d   = hit_any;
    if (frame_tick) begin
      pend_start_d = 1'b0;
      pend_hit_d   = 1'b0;
      case (mode_q)
        MODE_TITLE: if (start_any) mode_d = MODE_PLAY;
        MODE_PLAY:  if (hit_any)   mode_d = MODE_OVER;
        MODE_OVER:  if (start_any) mode_d = MODE_TITLE;
        default:    mode_d = MODE_TITLE;
      endcase
    end
  end

  // Double-dabble: 10 shift steps after the tick, digits swapped in as one word
  always_comb begin
    bcd_st_d = bcd_st_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    bcnt_d   = bcnt_q;
    digits_d = digits_q;
    bcd_adj  = bcd_q;
    case (bcd_st_q)
      BCD_SHIFT: begin
        for (int n = 0; n < 3; n++)
          if (bcd_adj[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_adj[4*n +: 4] + 4'd3;
        bcd_d  = {bcd_adj[10:0], bin_q[9]};
        bin_d  = {bin_q[8:0], 1'b0};
        bcnt_d = bcnt_q + 4'd1;
        if (bcnt_q == 4'd9) bcd_st_d = BCD_DONE;
      end
      BCD_DONE: begin
        digits_d = bcd_q;
        bcd_st_d = BCD_IDLE;
      end
      default: bcd_st_d = BCD_IDLE;
    endcase
    if (frame_tick) begin
      bin_d    = score;
      bcd_d    = '0;
      bcnt_d   = '0;
      bcd_st_d = BCD_SHIFT;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mode_q       <= MODE_TITLE;
      pend_start_q <= 1'b0;
      pend_hit_q   <= 1'b0;
      bird_y_q     <= '0;
      pipe0_x_q    <= '0;
      pipe1_x_q    <= '0;
      gap0_y_q     <= '0;
      gap1_y_q     <= '0;
      bcd_st_q     <= BCD_IDLE;
      bin_q        <= '0;
      bcd_q        <= '0;
      bcnt_q       <= '0;
      digits_q     <= '0;
    end else begin
      mode_q       <= mode_d;
      pend_start_q <= pend_start_d;
      pend_hit_q   <= pend_hit_d;
      bcd_st_q     <= bcd_st_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      bcnt_q       <= bcnt_d;
      digits_q     <= digits_d;
      if (frame_tick) begin
        bird_y_q  <= bird_y;
        pipe0_x_q <= pipe0_x;
        pipe1_x_q <= pipe1_x;
        gap0_y_q  <= gap0_y;
        gap1_y_q  <= gap1_y;
      end
    end
  end

  // Stage 1: rectangle tests against shadowed positions
  sprite_hit_calc #(.W(BIRD_W), .H(BIRD_H)) u_bird (
    .x_i(vif.pix_x), .y_i(vif.pix_y), .x0_i(10'(BIRD_X)), .y0_i(bird_y_q),
    .hit_o(hit_w[SPR_BIRD]), .lx_o(lx_w[SPR_BIRD]), .ly_o(ly_w[SPR_BIRD]));
  // Pipes span the full height from row 0, so ly is simply pix_y
  sprite_hit_calc #(.W(PIPE_W), .H(V_RES)) u_pipe0 (
    .x_i(vif.pix_x), .y_i(vif.pix_y), .x0_i(pipe0_x_q), .y0_i(9'd0),
    .hit_o(hit_w[SPR_PIPE0]), .lx_o(lx_w[SPR_PIPE0]), .ly_o(ly_w[SPR_PIPE0]));
  sprite_hit_calc #(.W(PIPE_W), .H(V_RES)) u_pipe1 (
    .x_i(vif.pix_x), .y_i(vif.pix_y), .x0_i(pipe1_x_q), .y0_i(9'd0),
    .hit_o(hit_w[SPR_PIPE1]), .lx_o(lx_w[SPR_PIPE1]), .ly_o(ly_w[SPR_PIPE1]));
  for (genvar k = 0; k < 3; k++) begin : g_dig
    sprite_hit_calc #(.W(DIG_W), .H(DIG_H)) u_dig (
      .x_i(vif.pix_x), .y_i(vif.pix_y), .x0_i(10'(DIG_X + k*DIG_W)), .y0_i(9'(DIG_Y)),
      .hit_o(hit_w[SPR_DIG0+k]), .lx_o(lx_w[SPR_DIG0+k]), .ly_o(ly_w[SPR_DIG0+k]));
  end
  sprite_hit_calc #(.W(GG_W), .H(GG_H)) u_gg (
    .x_i(vif.pix_x), .y_i(vif.pix_y), .x0_i(10'(GG_X)), .y0_i(9'(GG_Y)),
    .hit_o(hit_w[SPR_GG]), .lx_o(lx_w[SPR_GG]), .ly_o(ly_w[SPR_GG]));
  sprite_hit_calc #(.W(TT_W), .H(TT_H)) u_tt (
    .x_i(vif.pix_x), .y_i(vif.pix_y), .x0_i(10'(TT_X)), .y0_i(9'(TT_Y)),
    .hit_o(hit_w[SPR_TT]), .lx_o(lx_w[SPR_TT]), .ly_o(ly_w[SPR_TT]));

  always_comb begin
    for (int i = 0; i < N_SPR; i++) begin
      s1_d[i].hit = hit_w[i];
      s1_d[i].lx  = lx_w[i];
      s1_d[i].ly  = ly_w[i];
    end
    s1_d[SPR_PIPE0].hit = hit_w[SPR_PIPE0] && pipe_solid(vif.pix_y, gap0_y_q) && (pipe0_x_q < 10'(H_RES));
    s1_d[SPR_PIPE1].hit = hit_w[SPR_PIPE1] && pipe_solid(vif.pix_y, gap1_y_q) && (pipe1_x_q < 10'(H_RES));
  end

  // Stage 2: digit glyph selection, then mode-gated priority
  always_comb begin
    dig_hit  = 1'b0;
    dig_addr = '0;
    for (int k = 0; k < 3; k++)
      if (s1_q[SPR_DIG0+k].hit) begin
        dig_hit  = 1'b1;
        dig_addr = 19'(digits_q[4*(2-k) +: 4]) * 19'(DIG_ROM_BASE)
                 + rom_addr(s1_q[SPR_DIG0+k].ly, s1_q[SPR_DIG0+k].lx, DIG_W);
      end
  end

  always_comb begin
    mask_d    = MASK_BKG;
    address_d = '0;
    if (s1_valid_q) begin
      if (mode_q == MODE_OVER && s1_q[SPR_GG].hit) begin
        mask_d    = MASK_GAMEOVER;
        address_d = rom_addr(s1_q[SPR_GG].ly, s1_q[SPR_GG].lx, GG_W);
      end else if (mode_q == MODE_TITLE && s1_q[SPR_TT].hit) begin
        mask_d    = MASK_TITLE;
        address_d = rom_addr(s1_q[SPR_TT].ly, s1_q[SPR_TT].lx, TT_W);
      end else if (mode_q != MODE_TITLE && dig_hit) begin
        mask_d    = MASK_NUMBER;
        address_d = dig_addr;
      end else if (s1_q[SPR_BIRD].hit) begin
        mask_d    = MASK_BIRD;
        address_d = rom_addr(s1_q[SPR_BIRD].ly, s1_q[SPR_BIRD].lx, BIRD_W);
      end else if (mode_q != MODE_TITLE && s1_q[SPR_PIPE0].hit) begin
        mask_d    = MASK_PIPE;
        address_d = rom_addr(s1_q[SPR_PIPE0].ly, s1_q[SPR_PIPE0].lx, PIPE_W);
      end else if (mode_q != MODE_TITLE && s1_q[SPR_PIPE1].hit) begin
        mask_d    = MASK_PIPE;
        address_d = rom_addr(s1_q[SPR_PIPE1].ly, s1_q[SPR_PIPE1].lx, PIPE_W);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q  <= 1'b0;
      s1_oaddr_q  <= '0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      oaddress_q  <= '0;
      address_q   <= '0;
      mask_q      <= MASK_BKG;
    end else begin
      s1_valid_q  <= vif.pix_valid;
      s1_oaddr_q  <= 19'(vif.pix_y) * 19'(H_RES) + 19'(vif.pix_x);
      s1_q        <= s1_d;
      out_valid_q <= s1_valid_q;
      oaddress_q  <= s1_oaddr_q;
      address_q   <= address_d;
      mask_q      <= mask_d;
    end
  end

  assign vif.out_valid = out_valid_q;
  assign vif.oaddress  = oaddress_q;
  assign vif.address   = address_q;
  assign vif.mask      = mask_q;
  assign mode          = mode_q;
endmodule

// File: tb/tb_vga_sprite_scheduler.sv
// tb/tb_vga_sprite_scheduler.sv - bench for vga_sprite_scheduler
module tb_vga_sprite_scheduler;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  vga_sprite_if vif();
  logic       frame_tick, start_btn, hit;
  logic [8:0] bird_y, gap0_y, gap1_y;
  logic [9:0] pipe0_x, pipe1_x, score;
  logic [1:0] mode;

  vga_sprite_scheduler dut (
    .clock(clock), .resetn(resetn), .vif(vif), .frame_tick(frame_tick),
    .bird_y(bird_y), .pipe0_x(pipe0_x), .pipe1_x(pipe1_x), .gap0_y(gap0_y), .gap1_y(gap1_y),
    .score(score), .start_btn(start_btn), .hit(hit), .mode(mode));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Behavioural model: game state as seen by the scheduler
  int m_mode = 0, m_ps = 0, m_ph = 0;
  int m_bird_y = 0, m_p0x = 0, m_p1x = 0, m_g0y = 0, m_g1y = 0, m_score = 0;

  typedef struct {
    int valid;
    int oaddr;
    int mask;
    int addr;
  } exp_t;
  exp_t e1 = '{0, 0, 0, 0};
  exp_t e2 = '{0, 0, 0, 0};

  function automatic int in_rect(int x, int y, int rx, int ry, int w, int h);
    return int'(x >= rx && x < rx + w && y >= ry && y < ry + h);
  endfunction

  function automatic int pipe_at(int x, int y, int px, int gy);
    return int'(in_rect(x, y, px, 0, 52, 480) != 0 && !(y >= gy && y < gy + 120));
  endfunction

  function automatic exp_t model_pix(int v, int x, int y);
    exp_t r;
    int d[3];
    r.valid = v; r.oaddr = y * 640 + x; r.mask = 0; r.addr = 0;
    if (v == 0) return r;
    d[0] = m_score / 100; d[1] = (m_score / 10) % 10; d[2] = m_score % 10;
    if (m_mode == 2 && in_rect(x, y, 224, 180, 192, 42) != 0) begin
      r.mask = 4; r.addr = (y - 180) * 192 + (x - 224);
    end else if (m_mode == 0 && in_rect(x, y, 231, 120, 178, 48) != 0) begin
      r.mask = 5; r.addr = (y - 120) * 178 + (x - 231);
    end else if (m_mode != 0 && in_rect(x, y, 284, 20, 72, 36) != 0) begin
      r.mask = 3; r.addr = d[(x - 284) / 24] * 864 + (y - 20) * 24 + (x - 284) % 24;
    end else if (in_rect(x, y, 160, m_bird_y, 34, 24) != 0) begin
      r.mask = 1; r.addr = (y - m_bird_y) * 34 + (x - 160);
    end else if (m_mode != 0 && pipe_at(x, y, m_p0x, m_g0y) != 0) begin
      r.mask = 2; r.addr = y * 52 + (x - m_p0x);
    end else if (m_mode != 0 && pipe_at(x, y, m_p1x, m_g1y) != 0) begin
      r.mask = 2; r.addr = y * 52 + (x - m_p1x);
    end
    return r;
  endfunction

  always @(posedge clock) begin
    if (!resetn) begin
      m_mode = 0; m_ps = 0; m_ph = 0;
      m_bird_y = 0; m_p0x = 0; m_p1x = 0; m_g0y = 0; m_g1y = 0; m_score = 0;
      e1 = '{0, 0, 0, 0};
      e2 = '{0, 0, 0, 0};
    end else begin
      e2 = e1;
      e1 = model_pix(int'(vif.pix_valid), int'(vif.pix_x), int'(vif.pix_y));
      if (start_btn) m_ps = 1;
      if (hit) m_ph = 1;
      if (frame_tick) begin
        if (m_mode == 0 && m_ps != 0) m_mode = 1;
        else if (m_mode == 1 && m_ph != 0) m_mode = 2;
        else if (m_mode == 2 && m_ps != 0) m_mode = 0;
        m_ps = 0; m_ph = 0;
        m_bird_y = int'(bird_y); m_p0x = int'(pipe0_x); m_p1x = int'(pipe1_x);
        m_g0y = int'(gap0_y); m_g1y = int'(gap1_y); m_score = int'(score);
      end
    end
  end

  always @(negedge clock) begin
    chk("cmp.out_valid", int'(vif.out_valid), e2.valid);
    chk("cmp.mask", int'(vif.mask), e2.mask);
    chk("cmp.address", int'(vif.address), e2.addr);
    if (e2.valid != 0) chk("cmp.oaddress", int'(vif.oaddress), e2.oaddr);
    chk("cmp.mode", int'(mode), m_mode);
  end

  // Directed pixel with hand-computed mask/address; called at a negedge
  task automatic pix(input string name, input int x, input int y, input int em, input int ea);
    vif.pix_valid = 1'b1; vif.pix_x = 10'(x); vif.pix_y = 9'(y);
    @(negedge clock);
    vif.pix_valid = 1'b0;
    @(negedge clock);
    chk({name, ".mask"}, int'(vif.mask), em);
    chk({name, ".addr"}, int'(vif.address), ea);
    chk({name, ".oaddr"}, int'(vif.oaddress), y * 640 + x);
    chk({name, ".valid"}, int'(vif.out_valid), 1);
  endtask

  task automatic tick(input logic with_start, input logic with_hit);
    frame_tick = 1'b1; start_btn = with_start; hit = with_hit;
    @(negedge clock);
    frame_tick = 1'b0; start_btn = 1'b0; hit = 1'b0;
    repeat (20) @(negedge clock);
  endtask

  task automatic pulse(input logic s, input logic h);
    start_btn = s; hit = h;
    @(negedge clock);
    start_btn = 1'b0; hit = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    vif.pix_valid = 1'b0; vif.pix_x = '0; vif.pix_y = '0;
    frame_tick = 1'b0; start_btn = 1'b0; hit = 1'b0;
    bird_y = '0; pipe0_x = '0; pipe1_x = '0; gap0_y = '0; gap1_y = '0; score = '0;
    repeat (3) @(negedge clock);
    chk("rst.valid", int'(vif.out_valid), 0);
    chk("rst.mask", int'(vif.mask), 0);
    chk("rst.addr", int'(vif.address), 0);
    chk("rst.oaddr", int'(vif.oaddress), 0);
    chk("rst.mode", int'(mode), 0);
    resetn = 1'b1;
    @(negedge clock);

    pix("origin", 0, 0, 0, 0);
    pix("title_tl", 231, 120, 5, 0);
    pix("title_br", 408, 167, 5, 8543);
    pix("title_xend", 409, 167, 0, 0);

    bird_y = 9'd200; pipe0_x = 10'd300; gap0_y = 9'd100; pipe1_x = 10'd620; gap1_y = 9'd300;
    pulse(1'b1, 1'b0);
    repeat (5) @(negedge clock);
    chk("mode_hold", int'(mode), 0);
    tick(1'b0, 1'b0);
    chk("mode_play", int'(mode), 1);
    pix("bird_tl", 160, 200, 1, 0);
    pix("bird_br", 193, 223, 1, 815);
    pix("bird_xend", 194, 223, 0, 0);
    pix("pipe0_top", 310, 80, 2, 4170);
    pix("pipe0_gap", 310, 150, 0, 0);
    pix("gap_last", 310, 219, 0, 0);
    pix("gap_end", 310, 220, 2, 11450);
    pix("pipe0_right", 351, 80, 2, 4211);
    pix("pipe0_xend", 352, 80, 0, 0);
    pix("pipe1_edge", 639, 10, 2, 539);
    pix("num_zero", 284, 20, 3, 0);
    pix("num_over_pipe", 310, 50, 3, 722);

    score = 10'd907; pipe0_x = 10'd150; gap0_y = 9'd300;
    tick(1'b0, 1'b0);
    pix("dig1", 313, 22, 3, 53);
    pix("dig0", 284, 20, 3, 7776);
    pix("dig2_br", 355, 55, 3, 6911);
    pix("dig_xend", 356, 55, 0, 0);
    pix("bird_over_pipe", 170, 210, 1, 350);
    pix("pipe_by_bird", 195, 210, 2, 10965);

    pipe0_x = 10'd200;
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    chk("mode_over", int'(mode), 2);
    pix("gg_over_pipe", 224, 180, 4, 0);
    pix("gg_br", 415, 221, 4, 8063);
    pix("title_hidden", 231, 120, 2, 6271);
    pix("dig_in_over", 284, 20, 3, 7776);

    tick(1'b1, 1'b1);
    chk("mode_title_again", int'(mode), 0);
    pulse(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    chk("hit_dropped", int'(mode), 0);
    pix("title_again", 231, 120, 5, 0);
    pulse(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("pend_cleared", int'(mode), 1);
    tick(1'b0, 1'b1);
    chk("hit_on_tick", int'(mode), 2);

    vif.pix_valid = 1'b1; vif.pix_x = 10'd231; vif.pix_y = 9'd120;
    repeat (4) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("async.valid", int'(vif.out_valid), 0);
    chk("async.mask", int'(vif.mask), 0);
    chk("async.mode", int'(mode), 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("refill.first", int'(vif.out_valid), 0);
    @(negedge clock);
    chk("refill.second", int'(vif.out_valid), 1);
    chk("refill.mask", int'(vif.mask), 5);
    vif.pix_valid = 1'b0;
    repeat (4) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
